// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared definitions for the multiplier scheduler.
//   - FSM state encoding (IDLE / ISSUE / BUSY)
//   - operand, product, gain and channel-tag widths
//   - wrap_inc(): modulo-n increment used by the round-robin pointer
package mul_sched_pkg;

    localparam int OP_W   = 16;  // signed I/Q operand width
    localparam int PROD_W = 20;  // signed I/Q product width
    localparam int GAIN_W = 8;   // unsigned gain width
    localparam int TAG_W  = 3;   // channel tag width (up to 8 channels)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Increment v, wrapping to 0 after n-1.
    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] v, input int n);
        return (v == TAG_W'(n - 1)) ? '0 : v + TAG_W'(1);
    endfunction

endpackage

// File: rtl/mul_sched_rr_arb.sv
// mul_sched_rr_arb: NCH-wide round-robin picker.
// The winner is combinational from (req, pointer): the first set request bit
// scanning upward from the pointer, wrapping at NCH. When adv is high the
// pointer moves to one past the winner on the next rising edge.
//   clk, rst_n  clock, asynchronous active-low reset (pointer -> 0)
//   req         request vector
//   adv         accept the current winner (advance the pointer)
//   win_valid   at least one request is set
//   win_idx     index of the winning request
//   ptr         current pointer value
module mul_sched_rr_arb
    import mul_sched_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req,
    input  logic             adv,
    output logic             win_valid,
    output logic [TAG_W-1:0] win_idx,
    output logic [TAG_W-1:0] ptr
);

    logic [TAG_W-1:0] ptr_q;
    logic [TAG_W-1:0] ptr_d;
    logic             lo_found;
    logic             hi_found;
    logic [TAG_W-1:0] lo_idx;
    logic [TAG_W-1:0] hi_idx;

    // Scan from the top down so the lowest qualifying index is the last
    // assignment: hi_* is the lowest set bit at or above the pointer, lo_*
    // the lowest set bit overall (used when the scan has to wrap).
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found = 1'b1;
                lo_idx   = TAG_W'(j);
                if (TAG_W'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = TAG_W'(j);
                end
            end
        end
    end

    assign win_valid = lo_found;
    assign win_idx   = hi_found ? hi_idx : lo_idx;
    assign ptr       = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (adv && lo_found) begin
            ptr_d = wrap_inc(win_idx, NCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: time-shares one serial complex-by-scalar multiplier among NCH
// channels. Holds a per-channel gain register file, grants requests
// round-robin, issues one multiply at a time and returns each product tagged
// with its channel. A timeout flags a multiplier that never answers.
//   clk, rst_n           clock, asynchronous active-low reset
//   req / ack            per-channel request (held until ack) / capture pulse
//   dix, diy             per-channel signed I/Q operands, 16 bits per channel
//   cfg_we/ch/gain       gain register write port
//   mul_dix/diy/diz/iv   operands, gain and input strobe to the multiplier
//   mul_dox/doy/ov       products and output strobe from the multiplier
//   res_x/y/ch/v         registered product, channel tag, one-cycle strobe
//   busy                 FSM is not IDLE
//   err                  sticky timeout flag
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int LAT = 9,
    parameter int TMO = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req,
    input  logic [OP_W*NCH-1:0]   dix,
    input  logic [OP_W*NCH-1:0]   diy,
    output logic [NCH-1:0]        ack,
    input  logic                  cfg_we,
    input  logic [TAG_W-1:0]      cfg_ch,
    input  logic [GAIN_W-1:0]     cfg_gain,
    output logic [OP_W-1:0]       mul_dix,
    output logic [OP_W-1:0]       mul_diy,
    output logic [GAIN_W-1:0]     mul_diz,
    output logic                  mul_iv,
    input  logic [PROD_W-1:0]     mul_dox,
    input  logic [PROD_W-1:0]     mul_doy,
    input  logic                  mul_ov,
    output logic [PROD_W-1:0]     res_x,
    output logic [PROD_W-1:0]     res_y,
    output logic [TAG_W-1:0]      res_ch,
    output logic                  res_v,
    output logic                  busy,
    output logic                  err
);

    // A timeout shorter than the multiplier latency would abort every healthy
    // operation, so it is never allowed below LAT+1.
    localparam int TMO_EFF = (TMO > LAT) ? TMO : LAT + 1;
    localparam int CNT_W   = $clog2(TMO_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EFF - 1);

    // ------------------------------------------------------------------
    // Per-channel operand views
    // ------------------------------------------------------------------
    logic [OP_W-1:0] dix_ch [NCH];
    logic [OP_W-1:0] diy_ch [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign dix_ch[gi] = dix[gi*OP_W +: OP_W];
            assign diy_ch[gi] = diy[gi*OP_W +: OP_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Gain register file. Writes land on the next edge regardless of FSM
    // state; indices >= NCH match no entry and are dropped.
    // ------------------------------------------------------------------
    logic [GAIN_W-1:0] gain_q [NCH];
    logic [GAIN_W-1:0] gain_d [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            gain_d[i] = gain_q[i];
            if (cfg_we && (cfg_ch == TAG_W'(i))) begin
                gain_d[i] = cfg_gain;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                gain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                gain_q[i] <= gain_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic             win_valid;
    logic [TAG_W-1:0] win_idx;
    logic [TAG_W-1:0] rr_ptr;
    logic             grant;

    mul_sched_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .adv       (grant),
        .win_valid (win_valid),
        .win_idx   (win_idx),
        .ptr       (rr_ptr)
    );

    // Winner's operands and gain. The gain is read from gain_q, so a write
    // to the winning channel in the grant cycle is not yet visible here.
    logic [OP_W-1:0]   sel_dix;
    logic [OP_W-1:0]   sel_diy;
    logic [GAIN_W-1:0] sel_gain;

    always_comb begin
        sel_dix  = '0;
        sel_diy  = '0;
        sel_gain = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win_idx == TAG_W'(i)) begin
                sel_dix  = dix_ch[i];
                sel_diy  = diy_ch[i];
                sel_gain = gain_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------
    state_e            state_q,   state_d;
    logic [NCH-1:0]    ack_q,     ack_d;
    logic              mul_iv_q,  mul_iv_d;
    logic [OP_W-1:0]   mul_dix_q, mul_dix_d;
    logic [OP_W-1:0]   mul_diy_q, mul_diy_d;
    logic [GAIN_W-1:0] mul_diz_q, mul_diz_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [PROD_W-1:0] res_x_q,   res_x_d;
    logic [PROD_W-1:0] res_y_q,   res_y_d;
    logic [TAG_W-1:0]  res_ch_q,  res_ch_d;
    logic              res_pend_q, res_pend_d;
    logic              res_v_q,   res_v_d;
    logic              busy_q,    busy_d;
    logic              err_q,     err_d;

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        mul_iv_d   = 1'b0;
        mul_dix_d  = mul_dix_q;
        mul_diy_d  = mul_diy_q;
        mul_diz_d  = mul_diz_q;
        tag_d      = tag_q;
        cnt_d      = cnt_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
        res_ch_d   = res_ch_q;
        res_pend_d = 1'b0;
        // The product is captured on the mul_ov edge and announced one
        // cycle later, overlapping the IDLE cycle that may grant again.
        res_v_d    = res_pend_q;
        err_d      = err_q;
        grant      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant     = 1'b1;
                    state_d   = ST_ISSUE;
                    mul_iv_d  = 1'b1;
                    mul_dix_d = sel_dix;
                    mul_diy_d = sel_diy;
                    mul_diz_d = sel_gain;
                    tag_d     = win_idx;
                    for (int i = 0; i < NCH; i++) begin
                        ack_d[i] = (win_idx == TAG_W'(i));
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
                cnt_d   = '0;
            end
            ST_BUSY: begin
                if (mul_ov) begin
                    res_x_d    = mul_dox;
                    res_y_d    = mul_doy;
                    res_ch_d   = tag_q;
                    res_pend_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            mul_iv_q   <= 1'b0;
            mul_dix_q  <= '0;
            mul_diy_q  <= '0;
            mul_diz_q  <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
            res_ch_q   <= '0;
            res_pend_q <= 1'b0;
            res_v_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            mul_iv_q   <= mul_iv_d;
            mul_dix_q  <= mul_dix_d;
            mul_diy_q  <= mul_diy_d;
            mul_diz_q  <= mul_diz_d;
            tag_q      <= tag_d;
            cnt_q      <= cnt_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
            res_ch_q   <= res_ch_d;
            res_pend_q <= res_pend_d;
            res_v_q    <= res_v_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign ack     = ack_q;
    assign mul_iv  = mul_iv_q;
    assign mul_dix = mul_dix_q;
    assign mul_diy = mul_diy_q;
    assign mul_diz = mul_diz_q;
    assign res_x   = res_x_q;
    assign res_y   = res_y_q;
    assign res_ch  = res_ch_q;
    assign res_v   = res_v_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;
    import mul_sched_pkg::*;

    localparam int NCH = 4;
    localparam int LAT = 9;
    localparam int TMO = 16;
    localparam int PER = LAT + 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    req;
    logic [16*NCH-1:0] dix;
    logic [16*NCH-1:0] diy;
    logic [NCH-1:0]    ack;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [7:0]        cfg_gain;
    logic [15:0]       mul_dix, mul_diy;
    logic [7:0]        mul_diz;
    logic              mul_iv;
    logic [19:0]       mul_dox, mul_doy;
    logic              mul_ov;
    logic [19:0]       res_x, res_y;
    logic [2:0]        res_ch;
    logic              res_v, busy, err;

    mul_sched #(.NCH(NCH), .LAT(LAT), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dix(dix), .diy(diy), .ack(ack),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_gain(cfg_gain),
        .mul_dix(mul_dix), .mul_diy(mul_diy), .mul_diz(mul_diz), .mul_iv(mul_iv),
        .mul_dox(mul_dox), .mul_doy(mul_doy), .mul_ov(mul_ov),
        .res_x(res_x), .res_y(res_y), .res_ch(res_ch), .res_v(res_v),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Multiplier reference: signed 16 x unsigned 8 -> 24-bit, bits [23:4].
    function automatic logic [19:0] mulf(input logic [15:0] a, input logic [7:0] g);
        logic signed [24:0] p;
        p = $signed(a) * $signed({1'b0, g});
        return p[23:4];
    endfunction

    // ---------------- multiplier model + per-edge snapshots ----------------
    bit          withhold = 1'b0;
    bit          expect_result = 1'b1;
    int          cyc = 0;
    logic [7:0]  gain_m  [NCH] = '{default: 8'h00};
    logic [19:0] snap_x  [NCH] = '{default: 20'h0};
    logic [19:0] snap_y  [NCH] = '{default: 20'h0};
    logic [NCH-1:0] req_snap = '0;
    logic        pipe_v [LAT+1] = '{default: 1'b0};
    logic [19:0] pipe_x [LAT+1] = '{default: 20'h0};
    logic [19:0] pipe_y [LAT+1] = '{default: 20'h0};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_snap <= req;
        for (int k = 0; k < NCH; k++) begin
            snap_x[k] <= mulf(dix[k*16 +: 16], gain_m[k]);
            snap_y[k] <= mulf(diy[k*16 +: 16], gain_m[k]);
        end
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) gain_m[k] <= 8'h00;
        end else if (cfg_we && int'(cfg_ch) < NCH) begin
            gain_m[cfg_ch] <= cfg_gain;
        end
        pipe_v[0] <= mul_iv && !withhold;
        pipe_x[0] <= mulf(mul_dix, mul_diz);
        pipe_y[0] <= mulf(mul_diy, mul_diz);
        for (int s = 1; s <= LAT; s++) begin
            pipe_v[s] <= pipe_v[s-1];
            pipe_x[s] <= pipe_x[s-1];
            pipe_y[s] <= pipe_y[s-1];
        end
    end

    assign mul_ov  = pipe_v[LAT];
    assign mul_dox = pipe_x[LAT];
    assign mul_doy = pipe_y[LAT];

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        int          ch;
        logic [19:0] x;
        logic [19:0] y;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   ack_log[$];
    int   ack_cyc_log[$];
    int   tb_ptr  = 0;
    int   iv_cnt  = 0;
    int   ack3_cnt = 0;
    int   res_cnt = 0;

    always @(negedge clk) begin
        int   got_ch;
        int   exp_w;
        int   idx;
        exp_t e;
        if (!rst_n) begin
            tb_ptr = 0;
            sb.delete();
        end else begin
            if (mul_iv) iv_cnt++;
            if (ack[3]) ack3_cnt++;
            if (ack != '0) begin
                got_ch = -1;
                for (int k = 0; k < NCH; k++) if (ack[k]) got_ch = k;
                exp_w = NCH;
                for (int o = 0; o < NCH; o++) begin
                    idx = (tb_ptr + o) % NCH;
                    if (exp_w == NCH && req_snap[idx]) exp_w = idx;
                end
                check_eq("ack_onehot", $countones(ack), 1);
                check_eq("ack_winner", got_ch, exp_w);
                tb_ptr = (got_ch + 1) % NCH;
                ack_log.push_back(got_ch);
                ack_cyc_log.push_back(cyc);
                $display("[TB] grant ch=%0d cyc=%0d gain=%0h dix=%0h diy=%0h",
                         got_ch, cyc, mul_diz, mul_dix, mul_diy);
                if (expect_result) begin
                    e.ch  = got_ch;
                    e.x   = snap_x[got_ch];
                    e.y   = snap_y[got_ch];
                    e.cyc = cyc;
                    sb.push_back(e);
                end
            end
            if (res_v) begin
                res_cnt++;
                $display("[TB] result ch=%0d x=%0h y=%0h cyc=%0d", res_ch, res_x, res_y, cyc);
                if (sb.size() == 0) begin
                    check_eq("res_unexpected", res_v, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("res_ch", res_ch, e.ch);
                    check_eq("res_x", res_x, e.x);
                    check_eq("res_y", res_y, e.y);
                    check_eq("res_latency", cyc - e.cyc, PER);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int ch, input logic [7:0] g);
        step();
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_gain = g;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic set_op(input int ch, input logic [15:0] x, input logic [15:0] y);
        dix[ch*16 +: 16] = x;
        diy[ch*16 +: 16] = y;
    endtask

    task automatic wait_ack(input int ch);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (ack[ch]) return;
        end
        check_eq("ack_wait", ack[ch], 1'b1);
    endtask

    task automatic wait_acks(input int target);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            if (ack_log.size() >= target) break;
        end
        check_eq("ack_count", ack_log.size(), target);
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !busy) break;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base, iv0, a30, r0;
        req = '0; dix = '0; diy = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_gain = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_ack", ack, '0);
        check_eq("rst_iv", mul_iv, 1'b0);
        check_eq("rst_res_v", res_v, 1'b0);
        step();
        rst_n = 1'b1;

        // Single operation on channel 2
        cfg_write(2, 8'h40);
        set_op(2, 16'h1000, 16'hF000);
        req[2] = 1'b1;
        wait_ack(2);
        check_eq("t1_iv", mul_iv, 1'b1);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_diz", mul_diz, 8'h40);
        check_eq("t1_dix", mul_dix, 16'h1000);
        check_eq("t1_diy", mul_diy, 16'hF000);
        step();
        req[2] = 1'b0;
        @(negedge clk); #1;
        check_eq("t1_iv_pulse", mul_iv, 1'b0);
        check_eq("t1_ack_pulse", ack, '0);
        drain();
        check_eq("t1_res_x", res_x, 20'h04000);
        check_eq("t1_res_y", res_y, 20'hFC000);

        // All requests held: round-robin order, one grant every PER clocks
        cfg_write(0, 8'h11);
        cfg_write(1, 8'h22);
        cfg_write(3, 8'h7F);
        for (int k = 0; k < NCH; k++) set_op(k, 16'($urandom), 16'($urandom));
        base = ack_log.size();
        step();
        req = '1;
        wait_acks(base + 8);
        step();
        req = '0;
        drain();
        for (int i = 1; i < 8; i++) begin
            check_eq("t2_order", ack_log[base+i], (ack_log[base+i-1] + 1) % NCH);
            check_eq("t2_period", ack_cyc_log[base+i] - ack_cyc_log[base+i-1], PER);
        end

        // Gain write and grant to channel 1 on the same edge
        set_op(1, 16'h8000, 16'h7FFF);
        step();
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_gain = 8'h90;
        req[1] = 1'b1;
        step();
        cfg_we = 1'b0;
        wait_ack(1);
        check_eq("t3_old_gain", mul_diz, 8'h22);
        step();
        req[1] = 1'b0;
        drain();
        step();
        req[1] = 1'b1;
        wait_ack(1);
        check_eq("t3_new_gain", mul_diz, 8'h90);
        step();
        req[1] = 1'b0;
        drain();

        // req[3] withdrawn while channel 0 is busy
        set_op(0, 16'h0123, 16'hFEDC);
        a30 = ack3_cnt;
        step();
        req[0] = 1'b1;
        wait_ack(0);
        iv0 = iv_cnt;
        step();
        req[0] = 1'b0;
        req[3] = 1'b1;
        repeat (3) step();
        req[3] = 1'b0;
        drain();
        repeat (PER) @(negedge clk);
        #1;
        check_eq("t4_no_ack3", ack3_cnt - a30, 0);
        check_eq("t4_no_issue", iv_cnt - iv0, 0);

        // Multiplier never answers: timeout
        withhold = 1'b1;
        expect_result = 1'b0;
        r0 = res_cnt;
        step();
        req[2] = 1'b1;
        wait_ack(2);
        req[2] = 1'b0;
        for (int i = 1; i <= TMO + 1; i++) begin
            @(negedge clk); #1;
            check_eq("t5_err_time", err, (i == TMO + 1));
        end
        check_eq("t5_idle", busy, 1'b0);
        repeat (PER) @(negedge clk);
        #1;
        check_eq("t5_no_res", res_cnt - r0, 0);
        withhold = 1'b0;
        expect_result = 1'b1;
        set_op(0, 16'h7FFF, 16'h8001);
        step();
        req[0] = 1'b1;
        wait_ack(0);
        step();
        req[0] = 1'b0;
        drain();
        check_eq("t5_err_sticky", err, 1'b1);

        // Reset pulsed mid-BUSY
        expect_result = 1'b0;
        step();
        req[2] = 1'b1;
        wait_ack(2);
        req[2] = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_err", err, 1'b0);
        check_eq("t6_ack", ack, '0);
        check_eq("t6_iv", mul_iv, 1'b0);
        check_eq("t6_dix", mul_dix, 16'h0);
        check_eq("t6_diy", mul_diy, 16'h0);
        check_eq("t6_diz", mul_diz, 8'h0);
        check_eq("t6_res_x", res_x, 20'h0);
        check_eq("t6_res_y", res_y, 20'h0);
        check_eq("t6_res_ch", res_ch, 3'h0);
        check_eq("t6_res_v", res_v, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        r0 = res_cnt;
        repeat (2 * PER) @(negedge clk);
        #1;
        check_eq("t6_stale_ov", res_cnt - r0, 0);
        check_eq("t6_idle", busy, 1'b0);
        expect_result = 1'b1;
        cfg_write(1, 8'h05);
        cfg_write(3, 8'h09);
        set_op(1, 16'h0400, 16'hFC00);
        set_op(3, 16'h1234, 16'hEDCC);
        base = ack_log.size();
        step();
        req = 4'b1010;
        wait_acks(base + 2);
        step();
        req = '0;
        drain();
        check_eq("t6_first_ptr0", ack_log[base], 1);
        check_eq("t6_second", ack_log[base+1], 3);
        check_eq("end_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
